// File: rtl/sample_frame_tx.sv
// sample_frame_tx
//   Decimates an 8-bit sample stream and buffers the kept samples in a small
//   FIFO. Emits fixed-length frames on a valid/ready byte interface:
//   HDR0, HDR1, FRAME_LEN, FRAME_LEN payload bytes, and an optional checksum.
//
//   Optional feature: define SAMPLE_FRAME_CKSUM_EN to append a mod-256 sum of
//   the payload bytes as the last byte of each frame.
//
// Ports:
//   sclk      system clock, rising edge
//   rst_n     synchronous active-low reset; flushes the FIFO and abandons any frame
//   din/din_v sample stream from the sine generator
//   tx_data/tx_valid/tx_ready  outgoing byte handshake
//   busy      frame in progress
//   ovf_cnt   saturating count of samples dropped on a full FIFO
module sample_frame_tx #(
  parameter int          DEC_NUM    = 63,
  parameter int          FRAME_LEN  = 16,
  parameter int          FIFO_DEPTH = 32,
  parameter logic [7:0]  HDR0       = 8'h55,
  parameter logic [7:0]  HDR1       = 8'hAA
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_v,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DEC_NUM > 0) ? $clog2(DEC_NUM + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LEN, S_PAY
`ifdef SAMPLE_FRAME_CKSUM_EN
    , S_CKS
`endif
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  dec_cnt;
  logic [7:0]     byte_cnt, byte_cnt_nxt;
  logic [7:0]     data_nxt;
  logic [7:0]     head, head1;
  logic           capture, full, wr, hs, pop;
`ifdef SAMPLE_FRAME_CKSUM_EN
  logic [7:0]     cks, cks_nxt;
`endif

  assign capture = din_v && (dec_cnt == '0);
  // Fullness is taken before any same-cycle pop, so a write to a full FIFO
  // is dropped even when a payload byte leaves on the same edge.
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign wr      = capture && !full;
  assign hs      = tx_valid && tx_ready;
  assign pop     = hs && (state == S_PAY);
  assign head    = mem[rd_ptr];
  // tx_data is registered, so the byte after a pop is read one slot ahead.
  // Only used while payload bytes remain, so that slot is always filled.
  assign head1   = mem[rd_ptr + AW'(1)];

  always_ff @(posedge sclk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      ovf_cnt  <= 16'h0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      dec_cnt  <= '0;
      byte_cnt <= 8'h00;
`ifdef SAMPLE_FRAME_CKSUM_EN
      cks      <= 8'h00;
`endif
    end else begin
      if (din_v) dec_cnt <= (dec_cnt == DW'(DEC_NUM)) ? '0 : dec_cnt + DW'(1);
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (capture && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'h0001;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt      <= cnt + CW'(wr) - CW'(pop);
      state    <= state_nxt;
      tx_data  <= data_nxt;
      tx_valid <= (state_nxt != S_IDLE);
      busy     <= (state_nxt != S_IDLE);
      byte_cnt <= byte_cnt_nxt;
`ifdef SAMPLE_FRAME_CKSUM_EN
      cks      <= cks_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    data_nxt     = tx_data;
    byte_cnt_nxt = byte_cnt;
`ifdef SAMPLE_FRAME_CKSUM_EN
    cks_nxt      = cks;
`endif
    case (state)
      S_IDLE: if (cnt >= CW'(FRAME_LEN)) begin
        state_nxt = S_HDR0;
        data_nxt  = HDR0;
`ifdef SAMPLE_FRAME_CKSUM_EN
        cks_nxt   = 8'h00;
`endif
      end
      S_HDR0: if (hs) begin
        state_nxt = S_HDR1;
        data_nxt  = HDR1;
      end
      S_HDR1: if (hs) begin
        state_nxt    = S_LEN;
        data_nxt     = 8'(FRAME_LEN);
        byte_cnt_nxt = 8'h00;
      end
      S_LEN: if (hs) begin
        state_nxt = S_PAY;
        data_nxt  = head;
      end
      S_PAY: if (hs) begin
`ifdef SAMPLE_FRAME_CKSUM_EN
        cks_nxt = cks + tx_data;
`endif
        if (byte_cnt == 8'(FRAME_LEN - 1)) begin
`ifdef SAMPLE_FRAME_CKSUM_EN
          state_nxt = S_CKS;
          data_nxt  = cks + tx_data;
`else
          state_nxt = S_IDLE;
          data_nxt  = 8'h00;
`endif
        end else begin
          byte_cnt_nxt = byte_cnt + 8'h01;
          data_nxt     = head1;
        end
      end
`ifdef SAMPLE_FRAME_CKSUM_EN
      S_CKS: if (hs) begin
        state_nxt = S_IDLE;
        data_nxt  = 8'h00;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_frame_tx.sv
// Scoreboard bench for sample_frame_tx: two instances (no decimation and
// DEC_NUM=3), FRAME_LEN=4, FIFO_DEPTH=8. Expected frame bytes are queued by
// the stimulus; per-instance monitors pop and compare on each handshake.
module tb_sample_frame_tx;
  localparam int FL = 4;
`ifdef SAMPLE_FRAME_CKSUM_EN
  localparam int WLEN = FL + 4;
`else
  localparam int WLEN = FL + 3;
`endif

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00, din2 = 8'h00;
  logic        din_v = 1'b0, din_v2 = 1'b0;
  logic        tx_ready = 1'b0;
  logic        tx_ready2 = 1'b1;
  logic [7:0]  tx_data, tx_data2;
  logic        tx_valid, tx_valid2, busy, busy2;
  logic [15:0] ovf_cnt, ovf_cnt2;

  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$], exp_q2[$];

  always #5 sclk = ~sclk;

  sample_frame_tx #(.DEC_NUM(0), .FRAME_LEN(FL), .FIFO_DEPTH(8)) u_dut (
    .sclk(sclk), .rst_n(rst_n), .din(din), .din_v(din_v),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .ovf_cnt(ovf_cnt));

  sample_frame_tx #(.DEC_NUM(3), .FRAME_LEN(FL), .FIFO_DEPTH(8)) u_dec (
    .sclk(sclk), .rst_n(rst_n), .din(din2), .din_v(din_v2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .ovf_cnt(ovf_cnt2));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_frame(input bit sel, input logic [7:0] a, b, c, d);
    logic [7:0] f[$];
    logic [7:0] s;
    s = a + b + c + d;
    f = {8'h55, 8'hAA, 8'(FL), a, b, c, d};
`ifdef SAMPLE_FRAME_CKSUM_EN
    f.push_back(s);
`endif
    foreach (f[i]) begin
      if (sel) exp_q2.push_back(f[i]);
      else     exp_q.push_back(f[i]);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; one sample per call.
  task automatic send(input bit sel, input logic [7:0] d);
    if (sel) begin din2 = d; din_v2 = 1'b1; end
    else     begin din  = d; din_v  = 1'b1; end
    @(posedge sclk); #1;
    din_v = 1'b0; din_v2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  always @(negedge sclk) begin
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL mon_main: unexpected byte %h, expected none", tx_data);
      end else chk("mon_main byte", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
    end
  end

  always @(negedge sclk) begin
    if (tx_valid2 && tx_ready2) begin
      if (exp_q2.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL mon_dec: unexpected byte %h, expected none", tx_data2);
      end else chk("mon_dec byte", {8'h00, tx_data2}, {8'h00, exp_q2.pop_front()});
    end
  end

  initial begin
    int nb;
    bit found;

    // Reset state
    repeat (2) @(posedge sclk);
    #1;
    chk("rst tx_data", {8'h00, tx_data}, 16'h0000);
    chk("rst tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("rst busy", {15'h0, busy}, 16'h0000);
    chk("rst ovf_cnt", ovf_cnt, 16'h0000);
    chk("rst dec tx_valid", {15'h0, tx_valid2}, 16'h0000);
    rst_n = 1'b1;

    // Decimation by 4 with a 5-cycle din_v gap mid-stream (phase must hold)
    exp_frame(1, 8'h00, 8'h04, 8'h08, 8'h0C);
    exp_frame(1, 8'h10, 8'h14, 8'h18, 8'h1C);
    for (int i = 0; i < 18; i++) send(1, 8'(i));
    din2 = 8'hEE;
    repeat (5) tick();
    for (int i = 18; i < 32; i++) send(1, 8'(i));

    // Basic frame: tx_valid rises one edge after count reaches FRAME_LEN
    exp_frame(0, 8'h01, 8'h02, 8'h03, 8'h04);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(0, 8'(i));
    chk("valid low at count==FL", {15'h0, tx_valid}, 16'h0000);
    tick();
    chk("valid rise", {15'h0, tx_valid}, 16'h0001);
    chk("hdr0 first", {8'h00, tx_data}, 16'h0055);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      tick();
    end
    chk("busy cycles", 16'(nb), 16'(WLEN));

    // Backpressure during HDR1
    exp_frame(0, 8'h11, 8'h12, 8'h13, 8'h14);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h11 + i));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (tx_valid && tx_data == 8'hAA) found = 1'b1;
    end
    chk("hdr1 reached", {15'h0, found}, 16'h0001);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall data", {8'h00, tx_data}, 16'h00AA);
      chk("stall valid", {15'h0, tx_valid}, 16'h0001);
    end
    tx_ready = 1'b1;
    repeat (12) tick();

    // Overflow: 10 samples into an 8-deep FIFO with the sink stalled
    tx_ready = 1'b0;
    exp_frame(0, 8'h21, 8'h22, 8'h23, 8'h24);
    exp_frame(0, 8'h25, 8'h26, 8'h27, 8'h28);
    for (int i = 0; i < 10; i++) send(0, 8'(8'h21 + i));
    chk("ovf_cnt", ovf_cnt, 16'h0002);
    chk("ovf hdr0 held", {7'h0, tx_valid, tx_data}, 16'h0155);
    // Back-to-back drain: exactly one idle cycle between the two frames
    tx_ready = 1'b1;
    for (int k = 1; k <= 2 * WLEN + 1; k++) begin
      tick();
      chk($sformatf("b2b valid k=%0d", k), {15'h0, tx_valid},
          (k == WLEN || k == 2 * WLEN + 1) ? 16'h0000 : 16'h0001);
    end

    // Reset during the second payload byte
    exp_frame(0, 8'h31, 8'h32, 8'h33, 8'h34);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h31 + i));
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (tx_valid && tx_data == 8'h32) found = 1'b1;
    end
    chk("2nd payload reached", {15'h0, found}, 16'h0001);
    tx_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("midrst busy", {15'h0, busy}, 16'h0000);
    chk("midrst ovf_cnt", ovf_cnt, 16'h0000);
    exp_q.delete();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h41 + i));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post-rst quiet", {15'h0, tx_valid}, 16'h0000);
    end
    exp_frame(0, 8'h41, 8'h42, 8'h43, 8'h44);
    send(0, 8'h44);

    // Drain both scoreboards with a bounded wait
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) tick();
    chk("main queue drained", 16'(exp_q.size()), 16'h0000);
    chk("dec queue drained", 16'(exp_q2.size()), 16'h0000);
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
